// File: rtl/fifo_tree_pkg.sv
// Shared definitions for FIFO tree nodes: arbiter state encoding, default word
// width and a one-hot helper.
package fifo_tree_pkg;

    localparam int DEFAULT_DATA_WIDTH = 36;
    localparam int MAX_INPUTS         = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } arb_state_t;

    // Callers truncate the result to their own fan-in width.
    function automatic logic [MAX_INPUTS-1:0] onehot(input int unsigned idx);
        return MAX_INPUTS'(1) << idx;
    endfunction

endpackage

// File: rtl/fifo_tree_arbiter_rr_priority_picker.sv
// Combinational rotating-priority picker: first request at or above ptr, else
// the lowest request. Tying ptr to 0 gives fixed lowest-index priority.
module rr_priority_picker
    import fifo_tree_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int IDX_BITS   = $clog2(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] req,
    input  logic [IDX_BITS-1:0]   ptr,
    output logic [IDX_BITS-1:0]   grant_idx,
    output logic                  any_req
);

    logic                hi_found;
    logic [IDX_BITS-1:0] hi_idx;
    logic [IDX_BITS-1:0] lo_idx;

    // Scanning downward leaves the lowest matching index in each candidate.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = IDX_BITS'(i);
                if (i >= int'(ptr)) begin
                    hi_idx   = IDX_BITS'(i);
                    hi_found = 1'b1;
                end
            end
        end
        grant_idx = hi_found ? hi_idx : lo_idx;
        any_req   = |req;
    end

endmodule

// File: rtl/fifo_tree_arbiter.sv
// One FIFO tree node: arbitrates among child FIFOs, reads one word at a time
// and presents it on a valid/ready output. Define FIFO_ARB_FIXED_PRIO_EN for fixed priority.
module fifo_tree_arbiter
    import fifo_tree_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int IDX_BITS   = $clog2(NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_INPUTS-1:0]            empty_i,
    input  logic [NUM_INPUTS-1:0]            data_valid_i,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] data_i,
    output logic [NUM_INPUTS-1:0]            read_en_o,
    output logic [DATA_WIDTH-1:0]            out_data_o,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [IDX_BITS-1:0]              grant_idx_o,
    output logic                             drop_o
);

    arb_state_t          state;
    logic [IDX_BITS-1:0] pick_idx;
    logic [IDX_BITS-1:0] rr_ptr;
    logic                any_req;
    logic                sel_valid;
    logic [DATA_WIDTH-1:0] sel_data;

    rr_priority_picker #(
        .NUM_INPUTS (NUM_INPUTS),
        .IDX_BITS   (IDX_BITS)
    ) u_picker (
        .req       (~empty_i),
        .ptr       (rr_ptr),
        .grant_idx (pick_idx),
        .any_req   (any_req)
    );

`ifdef FIFO_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (state == IDLE && any_req) begin
            rr_ptr <= (int'(pick_idx) == NUM_INPUTS - 1) ? '0 : pick_idx + IDX_BITS'(1);
        end
    end
`endif

    // Read-data mux for the granted child.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (grant_idx_o == IDX_BITS'(k)) begin
                sel_valid = data_valid_i[k];
                sel_data  = data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            read_en_o   <= '0;
            out_data_o  <= '0;
            out_valid_o <= 1'b0;
            grant_idx_o <= '0;
            drop_o      <= 1'b0;
        end else begin
            drop_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_idx_o <= pick_idx;
                        read_en_o   <= NUM_INPUTS'(onehot(int'(pick_idx)));
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    read_en_o <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (sel_valid) begin
                        out_data_o  <= sel_data;
                        out_valid_o <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        drop_o <= 1'b1;
                        state  <= IDLE;
                    end
                end
                HOLD: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_tree_arbiter.sv
// Randomized and directed bench for fifo_tree_arbiter against a transaction-level reference model.
module tb_fifo_tree_arbiter;

    localparam int N  = 4;
    localparam int DW = 36;
    localparam int IB = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    empty_i;
    logic [N-1:0]    data_valid_i;
    logic [N*DW-1:0] data_i;
    logic [N-1:0]    read_en_o;
    logic [DW-1:0]   out_data_o;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [IB-1:0]   grant_idx_o;
    logic            drop_o;

    fifo_tree_arbiter #(.NUM_INPUTS(N), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .empty_i      (empty_i),
        .data_valid_i (data_valid_i),
        .data_i       (data_i),
        .read_en_o    (read_en_o),
        .out_data_o   (out_data_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .grant_idx_o  (grant_idx_o),
        .drop_o       (drop_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

`ifdef FIFO_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    // Reference model: m_since counts cycles since the grant (-1 = no transfer in progress).
    int            m_since = -1;
    int            m_ptr   = 0;
    int            m_g     = 0;
    logic [N-1:0]  m_rd    = '0;
    logic          m_valid = 1'b0;
    logic [DW-1:0] m_data  = '0;
    logic          m_drop  = 1'b0;
    int            cyc     = 0;

    task automatic model_edge();
        int base, pick, k;
        if (reset) begin
            m_since = -1; m_ptr = 0; m_g = 0;
            m_rd = '0; m_valid = 1'b0; m_data = '0; m_drop = 1'b0;
            return;
        end
        m_drop = 1'b0;
        if (m_since == -1) begin
            base = FIXED ? 0 : m_ptr;
            pick = -1;
            for (int off = 0; off < N; off++) begin
                k = (base + off) % N;
                if (pick < 0 && !empty_i[k]) pick = k;
            end
            if (pick >= 0) begin
                m_g = pick; m_rd = '0; m_rd[pick] = 1'b1;
                m_ptr = (pick + 1) % N; m_since = 1;
            end
        end else if (m_since == 1) begin
            m_rd = '0; m_since = 2;
        end else if (m_since == 2) begin
            if (data_valid_i[m_g]) begin
                m_data = data_i[m_g*DW +: DW]; m_valid = 1'b1; m_since = 3;
            end else begin
                m_drop = 1'b1; m_since = -1;
            end
        end else if (out_ready_i) begin
            m_valid = 1'b0; m_since = -1;
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check("read_en", 64'(read_en_o), 64'(m_rd));
        check("out_valid", 64'(out_valid_o), 64'(m_valid));
        check("out_data", 64'(out_data_o), 64'(m_data));
        check("grant_idx", 64'(grant_idx_o), 64'(m_g));
        check("drop", 64'(drop_o), 64'(m_drop));
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic set_word(input int k, input logic [DW-1:0] w);
        data_i[k*DW +: DW] = w;
    endtask

    int grants[$];
    int gcyc[$];

    initial begin
        reset = 1'b1; empty_i = '1; data_valid_i = '0; data_i = '0; out_ready_i = 1'b0;
        @(negedge clk);
        do_reset();
        check("reset_read_en", 64'(read_en_o), 64'd0);
        check("reset_grant", 64'(grant_idx_o), 64'd0);

        // Single source on child 2
        empty_i = 4'b1011; data_valid_i = 4'b0100; out_ready_i = 1'b1;
        set_word(2, 36'hA5);
        cycle();
        check("ss_read_en", 64'(read_en_o), 64'b0100);
        empty_i = 4'b1111;
        cycle();
        cycle();
        check("ss_valid", 64'(out_valid_o), 64'd1);
        check("ss_data", 64'(out_data_o), 64'hA5);
        check("ss_grant", 64'(grant_idx_o), 64'd2);
        cycle();
        check("ss_valid_one_cycle", 64'(out_valid_o), 64'd0);

        // Fairness, all children non-empty
        do_reset();
        empty_i = '0; data_valid_i = '1; out_ready_i = 1'b1;
        for (int k = 0; k < N; k++) set_word(k, DW'(36'h100 + k));
        grants.delete(); gcyc.delete();
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (read_en_o != '0) begin grants.push_back(int'(grant_idx_o)); gcyc.push_back(cyc); end
        end
        for (int i = 0; i < 5; i++) begin
            check("fair_order", 64'(grants[i]), FIXED ? 64'd0 : 64'(i % N));
            if (i > 0) check("fair_spacing", 64'(gcyc[i] - gcyc[i-1]), 64'd4);
        end

        // Backpressure on child 1
        do_reset();
        empty_i = 4'b1101; data_valid_i = '1; out_ready_i = 1'b0;
        set_word(1, 36'h123);
        repeat (3) cycle();
        check("bp_valid_rise", 64'(out_valid_o), 64'd1);
        repeat (10) begin
            cycle();
            check("bp_hold_valid", 64'(out_valid_o), 64'd1);
            check("bp_hold_data", 64'(out_data_o), 64'h123);
            check("bp_no_read", 64'(read_en_o), 64'd0);
        end
        out_ready_i = 1'b1; empty_i = '1;
        cycle();
        check("bp_release", 64'(out_valid_o), 64'd0);

        // Drop: granted child returns no data
        do_reset();
        empty_i = 4'b1100; data_valid_i = '0; out_ready_i = 1'b1;
        repeat (3) cycle();
        check("drop_pulse", 64'(drop_o), 64'd1);
        check("drop_no_valid", 64'(out_valid_o), 64'd0);
        cycle();
        check("drop_once", 64'(drop_o), 64'd0);
        check("drop_next_grant", 64'(grant_idx_o), FIXED ? 64'd0 : 64'd1);

        // Reset while holding a word
        do_reset();
        empty_i = 4'b1011; data_valid_i = '1; out_ready_i = 1'b0;
        set_word(2, 36'h5A5A);
        repeat (3) cycle();
        check("rh_valid", 64'(out_valid_o), 64'd1);
        reset = 1'b1;
        cycle();
        check("rh_valid_clr", 64'(out_valid_o), 64'd0);
        check("rh_data_clr", 64'(out_data_o), 64'd0);
        check("rh_grant_clr", 64'(grant_idx_o), 64'd0);
        check("rh_rd_clr", 64'(read_en_o), 64'd0);
        reset = 1'b0; empty_i = '0; out_ready_i = 1'b1;
        cycle();
        check("rh_first_grant", 64'(read_en_o), 64'b0001);

        // Wrap-around from pointer 3 with children 3 and 1 pending
        do_reset();
        empty_i = 4'b1011; data_valid_i = '1; out_ready_i = 1'b1;
        cycle();
        empty_i = '1;
        repeat (3) cycle();
        empty_i = 4'b0101;
        grants.delete();
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (read_en_o != '0) grants.push_back(int'(grant_idx_o));
        end
        check("wrap_count", 64'(grants.size()), 64'd2);
        if (grants.size() >= 2) begin
            check("wrap_first", 64'(grants[0]), FIXED ? 64'd1 : 64'd3);
            check("wrap_second", 64'(grants[1]), 64'd1);
        end

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 800; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            empty_i = N'($urandom);
            data_valid_i = ($urandom_range(0, 7) != 0) ? '1 : N'($urandom);
            for (int k = 0; k < N; k++) set_word(k, DW'({$urandom, $urandom}));
            out_ready_i = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
